dm_ctrl: RTL and testbench



---
 rtl/dm_ctrl_pkg.sv | 33 +++
 rtl/dm_ctrl_if.sv | 52 +++++
 rtl/dm_rr_arb.sv | 36 +++
 rtl/dm_ctrl.sv | 141 ++++++++++++++
 tb/tb_dm_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dm_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1,
        OP_PUSH  = 2'd2,
        OP_POP   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic ID_CORE = 1'b0;
    localparam logic ID_LD   = 1'b1;

    localparam logic [15:0] SP_RESET_DEF = 16'hFFFF;
    localparam logic [15:0] SP_LIMIT_DEF = 16'hFE00;

    // One latched request, whichever requester it came from.
    typedef struct packed {
        op_e         op;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic        id;
    } req_t;

endpackage

// File: rtl/dm_ctrl_if.sv
// Bundle of core request, loader request, response and data-memory bus signals.
// Latency: n/a (wires only).
// Backpressure: core_ready/ld_ready; requesters hold valid and payload until ready.
// slave  = controller view (dm_ctrl), master = environment view (core, loader, memory).
interface dm_ctrl_if;
    import dm_ctrl_pkg::*;

    logic        core_valid;
    op_e         core_op;
    logic [8:0]  core_addr;
    logic [15:0] core_wdata;
    logic        core_ready;

    logic        ld_valid;
    logic        ld_we;
    logic [8:0]  ld_addr;
    logic [15:0] ld_wdata;
    logic        ld_ready;

    logic        resp_valid;
    logic        resp_id;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [15:0] sp;

    logic        dm_store;
    logic        dm_push;
    logic        dm_pop;
    logic [15:0] dm_sp;
    logic [8:0]  dm_address;
    logic [15:0] dm_rez;
    logic [15:0] dm_rdata;

    modport slave (
        input  core_valid, core_op, core_addr, core_wdata,
        input  ld_valid, ld_we, ld_addr, ld_wdata,
        input  dm_rdata,
        output core_ready, ld_ready,
        output resp_valid, resp_id, resp_rdata, resp_err, sp,
        output dm_store, dm_push, dm_pop, dm_sp, dm_address, dm_rez
    );

    modport master (
        output core_valid, core_op, core_addr, core_wdata,
        output ld_valid, ld_we, ld_addr, ld_wdata,
        output dm_rdata,
        input  core_ready, ld_ready,
        input  resp_valid, resp_id, resp_rdata, resp_err, sp,
        input  dm_store, dm_push, dm_pop, dm_sp, dm_address, dm_rez
    );

endinterface

// File: rtl/dm_rr_arb.sv
// Two-way round-robin arbiter; req[0] = core, req[1] = loader.
// Latency: grant is combinational from req; pointer updates on the edge after en.
// Backpressure: en marks the grant as consumed; without en the pointer holds.
// Ports: clk, rst_n, req[1:0], en, gnt[1:0] (one-hot or zero).
module dm_rr_arb
    import dm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr_q;   // requester that has priority next

    always_comb begin
        gnt = 2'b00;
        if (ptr_q == ID_CORE) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

    // Priority passes to the requester that did not just win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= ID_CORE;
        else if (en)
            ptr_q <= gnt[0] ? ID_LD : ID_CORE;
    end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory access controller: owns the stack pointer, serialises load/store/push/pop.
// Latency: accept N, memory access N+1, resp_valid N+2; one access per 3 cycles.
// Backpressure: ready only in IDLE; losers and late requesters hold valid until ready.
// Ports: clk, rst_n, bus (dm_ctrl_if.slave: core/loader requests, response, sp, dm_* memory bus).
// Build option DM_CTRL_LOADER_EN: when defined, loader port and round-robin arbitration are live.
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter logic [15:0] SP_RESET = SP_RESET_DEF,
    parameter logic [15:0] SP_LIMIT = SP_LIMIT_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    dm_ctrl_if.slave  bus
);

    state_e      state_q, state_d;
    req_t        req_q;
    req_t        core_req, ld_req;
    logic [15:0] sp_q, sp_dec;
    logic [15:0] rdata_q;
    logic        err_q;
    logic        stk_err;
    logic [1:0]  arb_req, arb_gnt;
    logic        grant_en;

    assign core_req = '{op: bus.core_op, addr: bus.core_addr, wdata: bus.core_wdata, id: ID_CORE};

`ifdef DM_CTRL_LOADER_EN
    assign arb_req = {bus.ld_valid, bus.core_valid};
    assign ld_req  = '{op: (bus.ld_we ? OP_STORE : OP_LOAD), addr: bus.ld_addr,
                       wdata: bus.ld_wdata, id: ID_LD};
`else
    logic unused_ld;
    assign unused_ld = ^{bus.ld_valid, bus.ld_we, bus.ld_addr, bus.ld_wdata};
    assign arb_req   = {1'b0, bus.core_valid};
    assign ld_req    = '0;
`endif

    assign grant_en = (state_q == ST_IDLE) && (|arb_req);

    dm_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (arb_req),
        .en    (grant_en),
        .gnt   (arb_gnt)
    );

    assign bus.core_ready = grant_en & arb_gnt[0];
    assign bus.ld_ready   = grant_en & arb_gnt[1];

    // Bounds checks happen before the memory sees anything: a refused
    // push/pop still walks through ACCESS, but with every dm_* held low.
    assign sp_dec  = sp_q - 16'd1;
    assign stk_err = ((req_q.op == OP_PUSH) && (sp_dec < SP_LIMIT)) ||
                     ((req_q.op == OP_POP)  && (sp_q == SP_RESET));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (grant_en) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register only, so an asynchronous
    // reset drops every memory control immediately.
    always_comb begin
        bus.dm_store   = 1'b0;
        bus.dm_push    = 1'b0;
        bus.dm_pop     = 1'b0;
        bus.dm_sp      = '0;
        bus.dm_address = '0;
        bus.dm_rez     = '0;
        bus.resp_valid = (state_q == ST_RESP);
        bus.resp_id    = (state_q == ST_RESP) ? req_q.id : 1'b0;
        bus.resp_rdata = (state_q == ST_RESP) ? rdata_q : 16'h0;
        bus.resp_err   = (state_q == ST_RESP) ? err_q : 1'b0;
        if ((state_q == ST_ACCESS) && !stk_err) begin
            case (req_q.op)
                OP_LOAD: bus.dm_address = req_q.addr;
                OP_STORE: begin
                    bus.dm_store   = 1'b1;
                    bus.dm_address = req_q.addr;
                    bus.dm_rez     = req_q.wdata;
                end
                OP_PUSH: begin
                    bus.dm_push = 1'b1;
                    bus.dm_sp   = sp_dec;
                    bus.dm_rez  = req_q.wdata;
                end
                OP_POP: begin
                    bus.dm_pop = 1'b1;
                    bus.dm_sp  = sp_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.sp = sp_q;

    // Request latch, stack pointer and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            sp_q    <= SP_RESET;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (grant_en)
                req_q <= arb_gnt[1] ? ld_req : core_req;
            if (state_q == ST_ACCESS) begin
                err_q   <= stk_err;
                rdata_q <= '0;
                if (!stk_err) begin
                    case (req_q.op)
                        OP_LOAD: rdata_q <= bus.dm_rdata;
                        OP_PUSH: sp_q    <= sp_dec;
                        OP_POP: begin
                            rdata_q <= bus.dm_rdata;
                            sp_q    <= sp_q + 16'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl with a behavioural data/stack memory.
// Latency: checks accept N, ACCESS N+1, resp_valid N+2 on every transaction.
// Backpressure: requesters hold valid until ready; every wait on ready is cycle-bounded.
// Build option DM_CTRL_LOADER_EN selects the arbitration section matching the DUT build.
module tb_dm_ctrl;
    import dm_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dm_ctrl_if bus();

    dm_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: 512-word data space on dm_address, stack window
    // FE00..FFFF addressed by the low 9 bits of dm_sp. Read is combinational.
    logic [15:0] mem [0:511] = '{default: 16'h0};
    logic [15:0] stk [0:511] = '{default: 16'h0};

    assign bus.dm_rdata = bus.dm_pop ? stk[bus.dm_sp[8:0]] : mem[bus.dm_address];

    always @(posedge clk) begin
        if (bus.dm_store) mem[bus.dm_address] <= bus.dm_rez;
        if (bus.dm_push)  stk[bus.dm_sp[8:0]] <= bus.dm_rez;
    end

    // Observations from the last core transaction
    logic [2:0]  obs_ctl;   // {store, push, pop} during ACCESS
    logic [15:0] obs_sp;
    logic [8:0]  obs_addr;
    logic [15:0] obs_rez;
    logic        obs_vld;
    logic [15:0] obs_rdata;
    logic        obs_err;
    logic        obs_id;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One core request; returns with time just after the response edge.
    task automatic core_txn(input op_e op, input logic [8:0] addr, input logic [15:0] wdata);
        int k;
        @(negedge clk);
        bus.core_valid = 1'b1;
        bus.core_op    = op;
        bus.core_addr  = addr;
        bus.core_wdata = wdata;
        #1;
        k = 0;
        while (!bus.core_ready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!bus.core_ready) check_eq("core_ready_timeout", bus.core_ready, 1);
        @(posedge clk);
        #1;
        bus.core_valid = 1'b0;
        obs_ctl  = {bus.dm_store, bus.dm_push, bus.dm_pop};
        obs_sp   = bus.dm_sp;
        obs_addr = bus.dm_address;
        obs_rez  = bus.dm_rez;
        @(posedge clk);
        #1;
        obs_vld   = bus.resp_valid;
        obs_rdata = bus.resp_rdata;
        obs_err   = bus.resp_err;
        obs_id    = bus.resp_id;
    endtask

    initial begin
        int bad;
        int k;
        int last_cyc;
        logic seen;

        rst_n          = 1'b0;
        bus.core_valid = 1'b0;
        bus.core_op    = OP_LOAD;
        bus.core_addr  = '0;
        bus.core_wdata = '0;
        bus.ld_valid   = 1'b0;
        bus.ld_we      = 1'b0;
        bus.ld_addr    = '0;
        bus.ld_wdata   = '0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check_eq("rst_sp", bus.sp, 16'hFFFF);
        check_eq("rst_resp", {bus.resp_valid, bus.resp_err, bus.resp_id}, 3'b000);
        check_eq("rst_rdata", bus.resp_rdata, 16'h0);
        check_eq("rst_dm_ctl", {bus.dm_store, bus.dm_push, bus.dm_pop}, 3'b000);
        check_eq("rst_dm_bus", {bus.dm_sp, bus.dm_address, bus.dm_rez}, 41'h0);
        check_eq("rst_ready", {bus.core_ready, bus.ld_ready}, 2'b00);
        rst_n = 1'b1;

        // ---- push / pop ----
        core_txn(OP_PUSH, 9'h0, 16'hABCD);
        check_eq("push_ctl", obs_ctl, 3'b010);
        check_eq("push_dm_sp", obs_sp, 16'hFFFE);
        check_eq("push_rez", obs_rez, 16'hABCD);
        check_eq("push_resp", {obs_vld, obs_err}, 2'b10);
        check_eq("push_sp", bus.sp, 16'hFFFE);

        core_txn(OP_POP, 9'h0, 16'h0);
        check_eq("pop1_ctl", obs_ctl, 3'b001);
        check_eq("pop1_dm_sp", obs_sp, 16'hFFFE);
        check_eq("pop1_rdata", obs_rdata, 16'hABCD);
        check_eq("pop1_sp", bus.sp, 16'hFFFF);

        core_txn(OP_PUSH, 9'h0, 16'h1234);
        core_txn(OP_POP, 9'h0, 16'h0);
        check_eq("pop2_resp", {obs_vld, obs_err}, 2'b10);
        check_eq("pop2_rdata", obs_rdata, 16'h1234);
        check_eq("pop2_sp", bus.sp, 16'hFFFF);

        core_txn(OP_POP, 9'h0, 16'h0);
        check_eq("underflow_ctl", obs_ctl, 3'b000);
        check_eq("underflow_resp", {obs_vld, obs_err}, 2'b11);
        check_eq("underflow_rdata", obs_rdata, 16'h0);
        check_eq("underflow_sp", bus.sp, 16'hFFFF);

        // ---- store / load ----
        core_txn(OP_STORE, 9'h010, 16'h5A5A);
        check_eq("store_ctl", obs_ctl, 3'b100);
        check_eq("store_addr", obs_addr, 9'h010);
        check_eq("store_rez", obs_rez, 16'h5A5A);
        check_eq("store_resp", {obs_vld, obs_err, obs_rdata}, {2'b10, 16'h0});
        core_txn(OP_LOAD, 9'h010, 16'h0);
        check_eq("load_ctl", obs_ctl, 3'b000);
        check_eq("load_addr", obs_addr, 9'h010);
        check_eq("load_rdata", obs_rdata, 16'h5A5A);
        core_txn(OP_STORE, 9'h1FF, 16'h0F0F);
        core_txn(OP_LOAD, 9'h1FF, 16'h0);
        check_eq("load_top_rdata", obs_rdata, 16'h0F0F);
        core_txn(OP_LOAD, 9'h011, 16'h0);
        check_eq("load_blank_rdata", obs_rdata, 16'h0);

        // ---- arbitration, from reset ----
        reset_dut();
`ifdef DM_CTRL_LOADER_EN
        begin
            int core_left;
            int ld_left;
            logic exp_ld;
            core_left      = 4;
            ld_left        = 4;
            exp_ld         = 1'b0;
            last_cyc       = 0;
            bus.core_valid = 1'b1;
            bus.core_op    = OP_LOAD;
            bus.core_addr  = 9'h010;
            bus.ld_valid   = 1'b1;
            bus.ld_we      = 1'b0;
            bus.ld_addr    = 9'h1FF;
            for (int g = 0; g < 8; g++) begin
                #1;
                k = 0;
                while (!(bus.core_ready || bus.ld_ready) && k < 20) begin
                    @(negedge clk);
                    #1;
                    k++;
                end
                check_eq("rr_grant", {bus.core_ready, bus.ld_ready}, exp_ld ? 2'b01 : 2'b10);
                if (g > 0) check_eq("rr_gap", cyc - last_cyc, 3);
                last_cyc = cyc;
                @(posedge clk);
                #1;
                if (exp_ld) begin
                    ld_left--;
                    if (ld_left == 0) bus.ld_valid = 1'b0;
                end else begin
                    core_left--;
                    if (core_left == 0) bus.core_valid = 1'b0;
                end
                @(posedge clk);
                #1;
                check_eq("rr_resp_id", {bus.resp_valid, bus.resp_id}, {1'b1, exp_ld});
                check_eq("rr_rdata", bus.resp_rdata, exp_ld ? 16'h0F0F : 16'h5A5A);
                exp_ld = ~exp_ld;
                @(negedge clk);
            end

            // Loader write goes through as a store
            bus.ld_valid = 1'b1;
            bus.ld_we    = 1'b1;
            bus.ld_addr  = 9'h030;
            bus.ld_wdata = 16'h7777;
            #1;
            k = 0;
            while (!bus.ld_ready && k < 20) begin
                @(negedge clk);
                #1;
                k++;
            end
            check_eq("ld_store_ready", bus.ld_ready, 1);
            @(posedge clk);
            #1;
            bus.ld_valid = 1'b0;
            check_eq("ld_store_ctl", {bus.dm_store, bus.dm_address, bus.dm_rez}, {1'b1, 9'h030, 16'h7777});
            core_txn(OP_LOAD, 9'h030, 16'h0);
            check_eq("ld_store_readback", obs_rdata, 16'h7777);
        end
`else
        last_cyc       = 0;
        bus.core_valid = 1'b1;
        bus.core_op    = OP_LOAD;
        bus.core_addr  = 9'h010;
        bus.ld_valid   = 1'b1;
        bus.ld_we      = 1'b1;
        bus.ld_addr    = 9'h010;
        bus.ld_wdata   = 16'hFFFF;
        for (int g = 0; g < 3; g++) begin
            #1;
            k = 0;
            while (!bus.core_ready && k < 20) begin
                @(negedge clk);
                #1;
                k++;
            end
            check_eq("noldr_grant", {bus.core_ready, bus.ld_ready}, 2'b10);
            if (g > 0) check_eq("noldr_gap", cyc - last_cyc, 3);
            last_cyc = cyc;
            @(posedge clk);
            #1;
            if (g == 2) bus.core_valid = 1'b0;
            @(posedge clk);
            #1;
            check_eq("noldr_resp", {bus.resp_valid, bus.resp_id, bus.resp_rdata}, {2'b10, 16'h5A5A});
            @(negedge clk);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.ld_ready || bus.resp_valid || bus.dm_store) seen = 1'b1;
        end
        check_eq("noldr_ignored", seen, 1'b0);
        bus.ld_valid = 1'b0;
`endif

        // ---- fill stack to the limit ----
        bad = 0;
        for (int i = 0; i < 511; i++) begin
            core_txn(OP_PUSH, 9'h0, 16'h1000 + 16'(i));
            if (!obs_vld || obs_err) bad++;
        end
        check_eq("fill_errs", bad, 0);
        check_eq("fill_sp", bus.sp, 16'hFE00);
        core_txn(OP_PUSH, 9'h0, 16'hDEAD);
        check_eq("overflow_ctl", obs_ctl, 3'b000);
        check_eq("overflow_resp", {obs_vld, obs_err}, 2'b11);
        check_eq("overflow_sp", bus.sp, 16'hFE00);
        core_txn(OP_POP, 9'h0, 16'h0);
        check_eq("limit_pop_rdata", obs_rdata, 16'h11FE);
        check_eq("limit_pop_sp", bus.sp, 16'hFE01);

        // ---- reset during ACCESS of a store ----
        @(negedge clk);
        bus.core_valid = 1'b1;
        bus.core_op    = OP_STORE;
        bus.core_addr  = 9'h020;
        bus.core_wdata = 16'hBEEF;
        #1;
        k = 0;
        while (!bus.core_ready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        #1;
        bus.core_valid = 1'b0;
        check_eq("abort_store_on", bus.dm_store, 1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_store_drop", bus.dm_store, 0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.resp_valid || bus.dm_store) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.resp_valid || bus.dm_store) seen = 1'b1;
        end
        check_eq("abort_no_resp", seen, 1'b0);
        check_eq("abort_mem", mem[9'h020], 16'h0);
        check_eq("abort_sp", bus.sp, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
